// File: rtl/sram_owner_pkg.sv
// sram_owner_pkg: shared state encoding, default widths and the mask search helper
package sram_owner_pkg;
   localparam int MAX_STAGES     = 8;
   localparam int DEF_NUM_STAGES = 2;
   localparam int DEF_ADDR_W     = 18;
   localparam int DEF_DATA_W     = 16;
   typedef enum logic [2:0] {IDLE, UART_RX, SEL, RUN, GAP} owner_state_t;
   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } next_bit_t;
   // lowest set bit of mask at or above position from
   function automatic next_bit_t next_set_bit(input logic [MAX_STAGES-1:0] mask, input logic [3:0] from);
      next_bit_t r;
      r = '0;
      for (int i = MAX_STAGES - 1; i >= 0; i--)
         if (mask[i] && 4'(i) >= from) r = '{valid: 1'b1, idx: 3'(i)};
      return r;
   endfunction
endpackage

// File: rtl/sram_owner_mux.sv
// sram_owner_mux: selects which client drives the single SRAM port from the sequencer state
module sram_owner_mux
   import sram_owner_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STAGE_W    = 1
)(
   input  owner_state_t                 state,
   input  logic [STAGE_W-1:0]           active_stage,
   input  logic [ADDR_W-1:0]            uart_addr_i,
   input  logic [DATA_W-1:0]            uart_wdata_i,
   input  logic                         uart_we_n_i,
   input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
   input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
   input  logic [NUM_STAGES-1:0]        stage_we_n_i,
   input  logic [ADDR_W-1:0]            vga_addr_i,
   output logic [ADDR_W-1:0]            sram_addr_o,
   output logic [DATA_W-1:0]            sram_wdata_o,
   output logic                         sram_we_n_o
);
   // VGA reads when idle; stage writes are blocked outside RUN so handover cycles never write
   always_comb begin
      sram_addr_o  = vga_addr_i;
      sram_wdata_o = '0;
      sram_we_n_o  = 1'b1;
      if (state == UART_RX) begin
         sram_addr_o  = uart_addr_i;
         sram_wdata_o = uart_wdata_i;
         sram_we_n_o  = uart_we_n_i;
      end else if (state != IDLE) begin
         sram_addr_o  = stage_addr_i[active_stage*ADDR_W +: ADDR_W];
         sram_wdata_o = stage_wdata_i[active_stage*DATA_W +: DATA_W];
         sram_we_n_o  = (state == RUN) ? stage_we_n_i[active_stage] : 1'b1;
      end
   end
endmodule

// File: rtl/sram_owner_sequencer.sv
// sram_owner_sequencer: UART load, then masked stages in order, owning the SRAM port; SRAM_OWNER_WDOG_EN adds a per-stage watchdog
module sram_owner_sequencer
   import sram_owner_pkg::*;
#(
   parameter int NUM_STAGES  = DEF_NUM_STAGES,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = 50000000,
   parameter int WDOG_CYC    = 33554432,
   parameter int STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
)(
   input  logic                         CLOCK_50_I,
   input  logic                         resetn,
   input  logic                         uart_rx_i,
   input  logic [ADDR_W-1:0]            uart_addr_i,
   input  logic [DATA_W-1:0]            uart_wdata_i,
   input  logic                         uart_we_n_i,
   output logic                         uart_init_o,
   output logic                         uart_en_o,
   input  logic [NUM_STAGES-1:0]        stage_mask_i,
   output logic [NUM_STAGES-1:0]        stage_start_o,
   input  logic [NUM_STAGES-1:0]        stage_finish_i,
   input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
   input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
   input  logic [NUM_STAGES-1:0]        stage_we_n_i,
   input  logic [ADDR_W-1:0]            vga_addr_i,
   output logic [ADDR_W-1:0]            sram_addr_o,
   output logic [DATA_W-1:0]            sram_wdata_o,
   output logic                         sram_we_n_o,
   output logic                         vga_enable_o,
   output logic [STAGE_W-1:0]           active_stage_o,
`ifdef SRAM_OWNER_WDOG_EN
   output logic [NUM_STAGES-1:0]        wdog_err_o,
`endif
   output logic                         busy_o
);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
   if (NUM_STAGES < 1 || NUM_STAGES > MAX_STAGES || TIMEOUT_CYC < 1 || WDOG_CYC < 1) begin : g_bad_cfg
      $error("sram_owner_sequencer: unsupported parameter set");
   end
   owner_state_t       state, state_nx;
   logic [TMR_W-1:0]   timer;
   logic [STAGE_W-1:0] idx;
   logic [MAX_STAGES-1:0] mask_ext;
   next_bit_t          first_bit, next_bit;
   logic               timeout, stage_done;
   // widen the mask to the helper's fixed width
   always_comb begin
      mask_ext = '0;
      mask_ext[NUM_STAGES-1:0] = stage_mask_i;
   end
   assign first_bit = next_set_bit(mask_ext, 4'd0);
   assign next_bit  = next_set_bit(mask_ext, 4'(idx) + 4'd1);
   assign timeout   = uart_we_n_i && timer == TMR_W'(TIMEOUT_CYC - 1);
   assign busy_o    = state != IDLE;
`ifdef SRAM_OWNER_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYC + 1);
   logic [WD_W-1:0] wdog;
   logic            wdog_hit;
   assign wdog_hit   = state == RUN && wdog == WD_W'(WDOG_CYC - 1);
   assign stage_done = stage_finish_i[idx] || wdog_hit;
   // watchdog counts RUN cycles and records which stage it had to abandon
   always_ff @(posedge CLOCK_50_I or negedge resetn)
      if (!resetn) begin
         wdog       <= '0;
         wdog_err_o <= '0;
      end else begin
         wdog <= (state == RUN) ? wdog + 1'b1 : '0;
         if (wdog_hit) wdog_err_o[idx] <= 1'b1;
      end
`else
   assign stage_done = stage_finish_i[idx];
`endif
   // state register
   always_ff @(posedge CLOCK_50_I or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!uart_rx_i) state_nx = UART_RX;
         UART_RX: if (timeout) state_nx = first_bit.valid ? SEL : IDLE;
         SEL:     state_nx = RUN;
         RUN:     if (stage_done) state_nx = GAP;
         GAP:     state_nx = next_bit.valid ? SEL : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // registered outputs, idle timer and stage index follow the upcoming state
   always_ff @(posedge CLOCK_50_I or negedge resetn)
      if (!resetn) begin
         uart_init_o    <= 1'b0;
         uart_en_o      <= 1'b0;
         vga_enable_o   <= 1'b1;
         stage_start_o  <= '0;
         active_stage_o <= '0;
         timer          <= '0;
         idx            <= '0;
      end else begin
         uart_init_o   <= state == IDLE && state_nx == UART_RX;
         uart_en_o     <= state_nx == UART_RX && (uart_en_o || uart_init_o);
         vga_enable_o  <= state_nx == IDLE;
         stage_start_o <= (state_nx == RUN) ? (NUM_STAGES'(1) << idx) : '0;
         timer         <= (state == UART_RX && uart_we_n_i && !timeout) ? timer + 1'b1 : '0;
         if (state == SEL) active_stage_o <= idx;
         if (state == UART_RX && timeout) idx <= STAGE_W'(first_bit.idx);
         else if (state == GAP && next_bit.valid) idx <= STAGE_W'(next_bit.idx);
      end
   sram_owner_mux #(
      .NUM_STAGES(NUM_STAGES),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .STAGE_W   (STAGE_W)
   ) u_mux (
      .state        (state),
      .active_stage (active_stage_o),
      .uart_addr_i  (uart_addr_i),
      .uart_wdata_i (uart_wdata_i),
      .uart_we_n_i  (uart_we_n_i),
      .stage_addr_i (stage_addr_i),
      .stage_wdata_i(stage_wdata_i),
      .stage_we_n_i (stage_we_n_i),
      .vga_addr_i   (vga_addr_i),
      .sram_addr_o  (sram_addr_o),
      .sram_wdata_o (sram_wdata_o),
      .sram_we_n_o  (sram_we_n_o)
   );
endmodule

// File: tb/tb_sram_owner_sequencer.sv
// tb_sram_owner_sequencer: directed checks of load timeout, stage sequencing, SRAM routing and reset
module tb_sram_owner_sequencer;
   localparam int NS = 3;
   localparam int AW = 18;
   localparam int DW = 16;
   logic             CLOCK_50_I = 1'b0;
   logic             resetn = 1'b0;
   logic             uart_rx_i = 1'b1;
   logic [AW-1:0]    uart_addr_i = '0;
   logic [DW-1:0]    uart_wdata_i = 16'hABCD;
   logic             uart_we_n_i = 1'b1;
   logic             uart_init_o, uart_en_o;
   logic [NS-1:0]    stage_mask_i = 3'b101;
   logic [NS-1:0]    stage_start_o;
   logic [NS-1:0]    stage_finish_i = '0;
   logic [NS*AW-1:0] stage_addr_i = {18'h02222, 18'h11111, 18'h23C00};
   logic [NS*DW-1:0] stage_wdata_i = {16'h2222, 16'h1111, 16'h0C0C};
   logic [NS-1:0]    stage_we_n_i = 3'b110;
   logic [AW-1:0]    vga_addr_i = 18'h01234;
   logic [AW-1:0]    sram_addr_o;
   logic [DW-1:0]    sram_wdata_o;
   logic             sram_we_n_o, vga_enable_o, busy_o;
   logic [1:0]       active_stage_o;
`ifdef SRAM_OWNER_WDOG_EN
   logic [NS-1:0]    wdog_err_o;
`endif
   int               tests = 0, fails = 0, n;
   logic             s1_seen = 1'b0, any;
   logic [AW-1:0]    last_addr;
   logic             last_we;

   sram_owner_sequencer #(
      .NUM_STAGES (NS),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .TIMEOUT_CYC(100),
      .WDOG_CYC   (50)
   ) dut (
      .CLOCK_50_I    (CLOCK_50_I),
      .resetn        (resetn),
      .uart_rx_i     (uart_rx_i),
      .uart_addr_i   (uart_addr_i),
      .uart_wdata_i  (uart_wdata_i),
      .uart_we_n_i   (uart_we_n_i),
      .uart_init_o   (uart_init_o),
      .uart_en_o     (uart_en_o),
      .stage_mask_i  (stage_mask_i),
      .stage_start_o (stage_start_o),
      .stage_finish_i(stage_finish_i),
      .stage_addr_i  (stage_addr_i),
      .stage_wdata_i (stage_wdata_i),
      .stage_we_n_i  (stage_we_n_i),
      .vga_addr_i    (vga_addr_i),
      .sram_addr_o   (sram_addr_o),
      .sram_wdata_o  (sram_wdata_o),
      .sram_we_n_o   (sram_we_n_o),
      .vga_enable_o  (vga_enable_o),
      .active_stage_o(active_stage_o),
`ifdef SRAM_OWNER_WDOG_EN
      .wdog_err_o    (wdog_err_o),
`endif
      .busy_o        (busy_o)
   );

   always #5 CLOCK_50_I = ~CLOCK_50_I;
   always @(posedge CLOCK_50_I) if (stage_start_o[1]) s1_seen <= 1'b1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK_50_I);
      #1;
   endtask

   task automatic rx_pulse();
      tick();
      uart_rx_i = 1'b0;
      tick();
      uart_rx_i = 1'b1;
   endtask

   task automatic wait_start(output int cnt);
      cnt = 0;
      while (stage_start_o == '0 && cnt < 300) begin
         last_addr = sram_addr_o;
         last_we   = sram_we_n_o;
         tick();
         cnt++;
      end
   endtask

   initial begin
      #12;
      chk("rst_start", stage_start_o, 0);
      chk("rst_vga", vga_enable_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_init", uart_init_o, 0);
      chk("rst_en", uart_en_o, 0);
      chk("rst_active", active_stage_o, 0);
      chk("rst_we", sram_we_n_o, 1);
      chk("rst_addr", sram_addr_o, 18'h01234);
      resetn = 1'b1;
      tick();
      tick();
      rx_pulse();
      chk("init_pulse", uart_init_o, 1);
      chk("init_busy", busy_o, 1);
      chk("init_vga", vga_enable_o, 0);
      chk("init_en_low", uart_en_o, 0);
      tick();
      uart_addr_i = 18'd0;
      uart_we_n_i = 1'b0;
      chk("init_fall", uart_init_o, 0);
      chk("en_rise", uart_en_o, 1);
      tick();
      uart_addr_i = 18'd1;
      tick();
      uart_addr_i = 18'd2;
      #1;
      chk("uart_addr", sram_addr_o, 18'd2);
      chk("uart_we", sram_we_n_o, 0);
      chk("uart_wdata", sram_wdata_o, 16'hABCD);
      tick();
      uart_we_n_i = 1'b1;
      wait_start(n);
      chk("sel_latency", n, 101);
      chk("sel_addr", last_addr, 18'h23C00);
      chk("sel_we_forced", last_we, 1);
      chk("run0_start", stage_start_o, 3'b001);
      chk("run0_active", active_stage_o, 0);
      chk("run0_addr", sram_addr_o, 18'h23C00);
      chk("run0_we", sram_we_n_o, 0);
      chk("run0_uart_en", uart_en_o, 0);
      stage_finish_i = 3'b010;
      tick();
      chk("ignore_finish", stage_start_o, 3'b001);
      stage_finish_i = 3'b001;
      tick();
      chk("gap_start", stage_start_o, 0);
      chk("gap_busy", busy_o, 1);
      chk("gap_we", sram_we_n_o, 1);
      stage_finish_i = 3'b100;
      tick();
      chk("sel2_start", stage_start_o, 0);
      chk("sel2_we_forced", sram_we_n_o, 1);
      tick();
      chk("run2_start", stage_start_o, 3'b100);
      chk("run2_active", active_stage_o, 2);
      chk("run2_addr", sram_addr_o, 18'h02222);
      tick();
      chk("gap2_start", stage_start_o, 0);
      chk("gap2_busy", busy_o, 1);
      tick();
      chk("done_busy", busy_o, 0);
      chk("done_vga", vga_enable_o, 1);
      chk("done_addr", sram_addr_o, 18'h01234);
      chk("stage1_skipped", s1_seen, 0);
      stage_finish_i = 3'b000;
      stage_mask_i = 3'b000;
      rx_pulse();
      n = 0;
      any = 1'b0;
      while (busy_o && n < 300) begin
         any = any | (|stage_start_o);
         tick();
         n++;
      end
      chk("mask0_len", n, 100);
      chk("mask0_nostart", any, 0);
      chk("mask0_vga", vga_enable_o, 1);
      chk("mask0_en", uart_en_o, 0);
      stage_mask_i = 3'b010;
      rx_pulse();
      wait_start(n);
      chk("s1_latency", n, 101);
      chk("s1_start", stage_start_o, 3'b010);
      chk("s1_active", active_stage_o, 1);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst_start", stage_start_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_vga", vga_enable_o, 1);
      chk("arst_active", active_stage_o, 0);
      chk("arst_we", sram_we_n_o, 1);
      tick();
      resetn = 1'b1;
`ifdef SRAM_OWNER_WDOG_EN
      stage_mask_i = 3'b011;
      rx_pulse();
      wait_start(n);
      chk("wd_start0", stage_start_o, 3'b001);
      n = 0;
      while (stage_start_o == 3'b001 && n < 200) begin
         tick();
         n++;
      end
      chk("wd_len", n, 50);
      chk("wd_err", wdog_err_o, 3'b001);
      tick();
      tick();
      chk("wd_next", stage_start_o, 3'b010);
      stage_finish_i = 3'b010;
      tick();
      tick();
      chk("wd_done", busy_o, 0);
      chk("wd_err_keep", wdog_err_o, 3'b001);
      stage_finish_i = 3'b000;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/sram_owner_sequencer.md
Name: sram_owner_sequencer

Overview:
- Parametrised SRAM ownership sequencer for the decompressor top level.
- Receives the image over UART, detects end of transfer by an idle timeout, then runs up to NUM_STAGES processing stages in index order with start/finish handshakes.
- Each stage is individually maskable.
- Routes the single SRAM port to exactly one owner per cycle: UART, the active stage, or VGA when idle.

Parameters:
- NUM_STAGES, 2, number of processing-stage clients (1..8).
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- TIMEOUT_CYC, 50000000, UART idle cycles that end reception.
- WDOG_CYC, 33554432, per-stage watchdog limit (used only with the optional feature).

Ports:
- CLOCK_50_I  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- uart_rx_i  in  1  raw UART line; a low level in IDLE starts reception.
- uart_addr_i  in  ADDR_W  UART-side SRAM address.
- uart_wdata_i  in  DATA_W  UART-side write data.
- uart_we_n_i  in  1  UART-side write enable, active low.
- uart_init_o  out  1  UART receiver initialize pulse.
- uart_en_o  out  1  UART receiver enable.
- stage_mask_i  in  NUM_STAGES  bit k=1 means stage k runs.
- stage_start_o  out  NUM_STAGES  level start, one-hot or zero.
- stage_finish_i  in  NUM_STAGES  finish level from each stage.
- stage_addr_i  in  NUM_STAGES*ADDR_W  packed stage addresses; stage k occupies [k*ADDR_W +: ADDR_W].
- stage_wdata_i  in  NUM_STAGES*DATA_W  packed stage write data.
- stage_we_n_i  in  NUM_STAGES  stage write enables, active low.
- vga_addr_i  in  ADDR_W  VGA read address.
- sram_addr_o  out  ADDR_W  muxed SRAM address.
- sram_wdata_o  out  DATA_W  muxed SRAM write data.
- sram_we_n_o  out  1  muxed SRAM write enable.
- vga_enable_o  out  1  VGA fetch enable.
- active_stage_o  out  STAGE_W  index of the current stage; STAGE_W = max(1, clog2(NUM_STAGES)).
- busy_o  out  1  high when the sequencer is not in IDLE.

Behaviour:
- Reset (async, resetn low):
  - state=IDLE.
  - uart_init_o=0, uart_en_o=0, stage_start_o=0, vga_enable_o=1, active_stage_o=0.
  - Timer=0, stage index=0.
  - sram_we_n_o=1 (combinational, from the IDLE state).
- IDLE:
  - vga_enable_o=1.
  - On uart_rx_i==0: uart_init_o<=1, timer<=0, vga_enable_o<=0, go to UART_RX.
- UART_RX:
  - uart_init_o<=0. uart_en_o<=uart_init_o, so enable rises one cycle after the init pulse and stays high.
  - Timer increments every cycle and clears on any cycle with uart_we_n_i==0.
  - When timer==TIMEOUT_CYC-1: timer<=0, uart_en_o<=0, idx<=lowest set bit of stage_mask_i, go to SEL.
  - If the mask is all zero, go to IDLE instead.
- SEL (1 cycle):
  - stage_start_o<=one-hot(idx), active_stage_o<=idx, go to RUN.
- RUN:
  - Wait for stage_finish_i[idx]==1. finish_i of non-active stages is ignored.
  - On finish: stage_start_o<=0, go to GAP.
- GAP (1 cycle, guarantees start is low for at least one cycle between stages):
  - Compute the next set mask bit above idx.
  - If one exists: idx<=next, go to SEL. Otherwise go to IDLE.
- Mask sampling: stage_mask_i is sampled at the UART_RX exit and in GAP; changes mid-RUN have no effect on the current stage.
- SRAM mux (combinational on the registered state):
  - UART_RX: UART inputs.
  - SEL/RUN/GAP: the stage at active_stage_o. During SEL and GAP the we_n output is forced to 1.
  - IDLE: vga_addr_i, wdata=0, we_n=1.
- busy_o=(state!=IDLE).
- A finish that is already high on the cycle RUN is entered is accepted: minimum RUN length is 1 cycle.
- uart_rx_i activity outside IDLE is ignored.
- Reset mid-operation: everything returns to reset values at once; the stage sees start fall asynchronously.

Optional Feature:
- Macro: SRAM_OWNER_WDOG_EN.
- When defined:
  - A per-stage counter runs in RUN and clears in SEL.
  - When it reaches WDOG_CYC-1, the stage is treated as finished: start drops, a sticky bit wdog_err[idx] is set, and sequencing continues.
  - Extra output port wdog_err_o [NUM_STAGES], cleared only by reset.
- When undefined: the port and counter are absent, and RUN waits indefinitely.

Decomposition:
- Package sram_owner_pkg holds:
  - enum owner_state_t {IDLE, UART_RX, SEL, RUN, GAP};
  - default widths;
  - function next_set_bit(mask, from) returning index and a valid flag.
- One natural sub-module: sram_owner_mux, the purely combinational owner-select of addr/wdata/we_n.

Test Plan:
- uart_rx_i pulled low in IDLE, 3 writes at addr 0,1,2, then quiet with TIMEOUT_CYC=100 → uart_init_o pulses 1 cycle. State goes to SEL exactly 100 cycles after the last uart_we_n_i low.
- NUM_STAGES=3, mask=3'b101 → start_o sequence 001, then 000 (GAP), then 100. Stage 1 is never started. busy_o falls the cycle after stage 2 finishes.
- Stage 0 drives addr=18'h23C00, we_n=0 in RUN → sram_addr_o=18'h23C00, sram_we_n_o=0. The same input during SEL gives we_n_o=1.
- Mask=0 at timeout → direct return to IDLE, stage_start_o stays 0, vga_enable_o=1.
- resetn asserted during RUN of stage 1 → start_o=0, state=IDLE, vga_enable_o=1 with no clock edge.
- With SRAM_OWNER_WDOG_EN, WDOG_CYC=50, finish never asserted → start drops after 50 RUN cycles, wdog_err_o[0]=1, next stage starts.
